// File: rtl/axis_pkg.sv
// Shared AXI4-Stream definitions: beat layout {tlast, tkeep, tdata} and width helpers.
package axis_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    function automatic int keep_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int beat_width(input int data_width);
        return data_width + keep_width(data_width) + 1;
    endfunction

    typedef struct packed {
        logic                              tlast;
        logic [DEFAULT_DATA_WIDTH/8-1:0]   tkeep;
        logic [DEFAULT_DATA_WIDTH-1:0]     tdata;
    } axis_beat_t;

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, asynchronous (show-ahead) read.
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = beat_width(DEFAULT_DATA_WIDTH)
) (
    input  logic                     aclk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream synchronous FIFO with fill level, almost flags and optional
// store-and-forward gating of packet starts.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = keep_width(DATA_WIDTH),
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0,
    parameter int AF_LEVEL    = DEPTH - 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   pkt_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = DATA_WIDTH + KEEP_WIDTH + 1;
    localparam logic [PW-1:0] ONE    = PW'(1);
    localparam logic [PW-1:0] AF_LVL = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] level_reg, level_next;
    logic [PW-1:0] pkt_count_reg, pkt_count_next;
    logic          release_reg, release_next;
    logic          in_pkt_reg, in_pkt_next;
    logic          rst_done_reg;

    logic          empty, full;
    logic          wr_en, rd_en, wr_last, rd_last;
    logic          out_allowed;
    logic [BW-1:0] wr_beat, rd_beat;

    // The extra pointer bit distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

    assign s_axis_tready = rst_done_reg && !full;
    assign m_axis_tvalid = !empty && out_allowed;

    assign wr_en   = s_axis_tvalid && s_axis_tready;
    assign rd_en   = m_axis_tvalid && m_axis_tready;
    assign wr_last = wr_en && s_axis_tlast;
    assign rd_last = rd_en && m_axis_tlast;

    assign wr_beat = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_beat;

    // Store-and-forward gates only the first beat of a packet; an oversize
    // packet that fills the FIFO is released to avoid deadlock.
    generate
        if (PACKET_MODE != 0) begin : g_store_fwd
            assign out_allowed = in_pkt_reg || (pkt_count_reg != '0) || release_reg;
        end else begin : g_cut_through
            assign out_allowed = 1'b1;
        end
    endgenerate

    always_comb begin
        wr_ptr_next    = wr_en ? wr_ptr_reg + ONE : wr_ptr_reg;
        rd_ptr_next    = rd_en ? rd_ptr_reg + ONE : rd_ptr_reg;

        level_next     = level_reg;
        if (wr_en && !rd_en) begin
            level_next = level_reg + ONE;
        end else if (!wr_en && rd_en) begin
            level_next = level_reg - ONE;
        end

        pkt_count_next = pkt_count_reg;
        if (wr_last && !rd_last) begin
            pkt_count_next = pkt_count_reg + ONE;
        end else if (!wr_last && rd_last) begin
            pkt_count_next = pkt_count_reg - ONE;
        end

        release_next   = release_reg;
        if (rd_last) begin
            release_next = 1'b0;
        end else if (full && (pkt_count_reg == '0)) begin
            release_next = 1'b1;
        end

        in_pkt_next    = rd_en ? !m_axis_tlast : in_pkt_reg;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            pkt_count_reg <= '0;
            release_reg   <= 1'b0;
            in_pkt_reg    <= 1'b0;
            rst_done_reg  <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            pkt_count_reg <= pkt_count_next;
            release_reg   <= release_next;
            in_pkt_reg    <= in_pkt_next;
            rst_done_reg  <= 1'b1;
        end
    end

    assign level        = level_reg;
    assign pkt_count    = pkt_count_reg;
    assign almost_full  = (level_reg >= AF_LVL);
    assign almost_empty = (level_reg <= AE_LVL);

    axis_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BW)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data (wr_beat),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (rd_beat)
    );

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo: instance 0 is cut-through, instance 1 store-and-forward.
module tb_axis_pkt_fifo;
    import axis_pkg::*;

    localparam int DW    = 32;
    localparam int KW    = 4;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;

    logic          s_tvalid [2];
    logic          s_tready [2];
    logic [DW-1:0] s_tdata  [2];
    logic [KW-1:0] s_tkeep  [2];
    logic          s_tlast  [2];
    logic          m_tvalid [2];
    logic          m_tready [2];
    logic [DW-1:0] m_tdata  [2];
    logic [KW-1:0] m_tkeep  [2];
    logic          m_tlast  [2];
    logic [LW-1:0] level    [2];
    logic [LW-1:0] pkt_count[2];
    logic          almost_full [2];
    logic          almost_empty[2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            axis_pkt_fifo #(
                .DATA_WIDTH  (DW),
                .KEEP_WIDTH  (KW),
                .DEPTH       (DEPTH),
                .PACKET_MODE (gi),
                .AF_LEVEL    (DEPTH - 2),
                .AE_LEVEL    (2)
            ) dut (
                .aclk          (aclk),
                .aresetn       (aresetn),
                .s_axis_tvalid (s_tvalid[gi]),
                .s_axis_tready (s_tready[gi]),
                .s_axis_tdata  (s_tdata[gi]),
                .s_axis_tkeep  (s_tkeep[gi]),
                .s_axis_tlast  (s_tlast[gi]),
                .m_axis_tvalid (m_tvalid[gi]),
                .m_axis_tready (m_tready[gi]),
                .m_axis_tdata  (m_tdata[gi]),
                .m_axis_tkeep  (m_tkeep[gi]),
                .m_axis_tlast  (m_tlast[gi]),
                .level         (level[gi]),
                .almost_full   (almost_full[gi]),
                .almost_empty  (almost_empty[gi]),
                .pkt_count     (pkt_count[gi])
            );
        end
    endgenerate

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    axis_beat_t q0[$];
    axis_beat_t q1[$];
    int lvl_m[2];
    int pc_m[2];
    bit post_rst = 1'b0;
    bit rand_rd[2];
    bit mwr, mrd;
    axis_beat_t mgot, mexp;

    always @(posedge aclk) cyc++;

    task automatic check(input string name, input int i, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at t=%0t", name, i, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, record its expected output.
    task automatic send(input int i, input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        int t;
        axis_beat_t b;
        s_tvalid[i] = 1'b1;
        s_tdata[i]  = d;
        s_tkeep[i]  = k;
        s_tlast[i]  = l;
        t = 0;
        @(negedge aclk);
        while (!s_tready[i] && t < 200) begin
            t++;
            @(negedge aclk);
        end
        if (!s_tready[i]) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout dut%0d: got no tready expected tready within 200 cycles", i);
        end else begin
            b.tlast = l;
            b.tkeep = k;
            b.tdata = d;
            if (i == 0) q0.push_back(b);
            else        q1.push_back(b);
        end
        @(posedge aclk);
        #1;
        s_tvalid[i] = 1'b0;
    endtask

    task automatic wait_drain(input int i);
        int t;
        t = 0;
        while ((level[i] != '0 || qsize(i) != 0) && t < 3000) begin
            tick(1);
            t++;
        end
        check("drain_level", i, level[i], 0);
        check("drain_queue", i, qsize(i), 0);
    endtask

    // Monitor: checks every output beat against the scoreboard and the status outputs
    // against a level/packet model, then advances the model by this cycle's handshakes.
    always @(negedge aclk) begin
        if (!aresetn) begin
            q0.delete();
            q1.delete();
            lvl_m    = '{0, 0};
            pc_m     = '{0, 0};
            post_rst = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                check("level", i, level[i], lvl_m[i]);
                check("pkt_count", i, pkt_count[i], pc_m[i]);
                check("s_tready", i, s_tready[i], post_rst && (lvl_m[i] < DEPTH));
                check("almost_full", i, almost_full[i], lvl_m[i] >= DEPTH - 2);
                check("almost_empty", i, almost_empty[i], lvl_m[i] <= 2);
                if (i == 0) check("m_tvalid", i, m_tvalid[i], lvl_m[i] != 0);
                mwr = s_tvalid[i] && post_rst && (lvl_m[i] < DEPTH);
                mrd = m_tvalid[i] && m_tready[i];
                if (mrd) begin
                    if (qsize(i) == 0) begin
                        check("unexpected_beat", i, 1, 0);
                    end else begin
                        if (i == 0) mexp = q0.pop_front();
                        else        mexp = q1.pop_front();
                        mgot.tlast = m_tlast[i];
                        mgot.tkeep = m_tkeep[i];
                        mgot.tdata = m_tdata[i];
                        check("beat", i, mgot, mexp);
                        if (mexp.tlast) pc_m[i]--;
                    end
                end
                if (mwr && s_tlast[i]) pc_m[i]++;
                lvl_m[i] = lvl_m[i] + (mwr ? 1 : 0) - (mrd ? 1 : 0);
            end
            post_rst = 1'b1;
        end
    end

    always @(posedge aclk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rand_rd[i]) m_tready[i] = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid[i] = 1'b0;
            s_tdata[i]  = '0;
            s_tkeep[i]  = '0;
            s_tlast[i]  = 1'b0;
            m_tready[i] = 1'b0;
            rand_rd[i]  = 1'b0;
        end
        #2 aresetn = 1'b0;
        tick(2);
        for (int i = 0; i < 2; i++) begin
            check("rst_level", i, level[i], 0);
            check("rst_pkt_count", i, pkt_count[i], 0);
            check("rst_m_tvalid", i, m_tvalid[i], 0);
            check("rst_s_tready", i, s_tready[i], 0);
            check("rst_almost_empty", i, almost_empty[i], 1);
            check("rst_almost_full", i, almost_full[i], 0);
        end
        aresetn = 1'b1;
        tick(1);
        for (int i = 0; i < 2; i++) check("post_rst_s_tready", i, s_tready[i], 1);

        // Fill 16 beats with output stalled, then drain in order.
        for (int k = 0; k < 16; k++) begin
            send(0, DW'(k), 4'hF, k == 15);
            check("fill_level", 0, level[0], k + 1);
            check("fill_almost_full", 0, almost_full[0], (k + 1) >= 14);
        end
        check("full_s_tready", 0, s_tready[0], 0);
        check("full_pkt_count", 0, pkt_count[0], 1);
        m_tready[0] = 1'b1;
        wait_drain(0);
        check("drained_almost_empty", 0, almost_empty[0], 1);
        m_tready[0] = 1'b0;

        // Full FIFO with continuous traffic: one stall, then one beat per cycle across wrap.
        for (int k = 0; k < 16; k++) send(0, 32'h100 + DW'(k), 4'hF, 1'b0);
        m_tready[0] = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 20; k++) send(0, 32'h200 + DW'(k), 4'hF, 1'b0);
        check("stream_cycles", 0, cyc - c0, 21);
        check("stream_level", 0, level[0], 15);
        wait_drain(0);
        m_tready[0] = 1'b0;

        // Store-and-forward: output withheld until the tlast beat is stored.
        m_tready[1] = 1'b1;
        send(1, 32'hA0, 4'hF, 1'b0);
        check("sf_hold_beat1", 1, m_tvalid[1], 0);
        send(1, 32'hA1, 4'hF, 1'b0);
        check("sf_hold_beat2", 1, m_tvalid[1], 0);
        send(1, 32'hA2, 4'h3, 1'b1);
        check("sf_release_tvalid", 1, m_tvalid[1], 1);
        check("sf_pkt_count", 1, pkt_count[1], 1);
        wait_drain(1);
        check("sf_pkt_count_end", 1, pkt_count[1], 0);

        // Oversize packet: full with no complete packet releases the output.
        m_tready[1] = 1'b0;
        for (int k = 0; k < 16; k++) send(1, 32'hB00 + DW'(k), 4'hF, 1'b0);
        check("big_level", 1, level[1], 16);
        check("big_pkt_count", 1, pkt_count[1], 0);
        check("big_gated", 1, m_tvalid[1], 0);
        tick(1);
        check("big_released", 1, m_tvalid[1], 1);
        m_tready[1] = 1'b1;
        for (int k = 16; k < 20; k++) send(1, 32'hB00 + DW'(k), 4'hF, 1'b0);
        wait_drain(1);
        m_tready[1] = 1'b0;
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        tick(1);

        // Random valid/ready traffic on both modes.
        for (int i = 0; i < 2; i++) begin
            rand_rd[i] = 1'b1;
            for (int n = 0; n < 1000; n++) begin
                if ($urandom_range(0, 1) == 1) tick(1);
                send(i, $urandom, 4'($urandom), (n == 999) || ($urandom_range(0, 3) == 0));
            end
            wait_drain(i);
            rand_rd[i] = 1'b0;
            tick(1);
            m_tready[i] = 1'b0;
        end

        // Reset mid-stream with 7 beats stored.
        for (int k = 0; k < 7; k++) send(0, 32'h300 + DW'(k), 4'hF, k == 2);
        check("mid_level", 0, level[0], 7);
        check("mid_pkt_count", 0, pkt_count[0], 1);
        aresetn = 1'b0;
        tick(1);
        check("mid_rst_level", 0, level[0], 0);
        check("mid_rst_pkt_count", 0, pkt_count[0], 0);
        check("mid_rst_m_tvalid", 0, m_tvalid[0], 0);
        check("mid_rst_s_tready", 0, s_tready[0], 0);
        aresetn = 1'b1;
        tick(1);
        check("mid_post_s_tready", 0, s_tready[0], 1);
        m_tready[0] = 1'b1;
        send(0, 32'hABC, 4'hF, 1'b1);
        check("mid_first_tvalid", 0, m_tvalid[0], 1);
        check("mid_first_tdata", 0, m_tdata[0], 32'hABC);
        wait_drain(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
